cv32e40p_alu_fault_manager: RTL and testbench

CV32E40P_ALU_FAULT_MANAGER -- requirements
Module: cv32e40p_alu_fault_manager

---
 rtl/cv32e40p_alu_fault_manager.sv | 131 +++++++++++++
 tb/tb_cv32e40p_alu_fault_manager.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_alu_fault_manager.sv
// Fault manager for a triplicated ALU: counts qualified voter disagreements per replica
// and steps HEALTHY -> DEGRADED (spare swapped in) -> FAILED as counters hit THRESHOLD.
module cv32e40p_alu_fault_manager #(
    parameter int unsigned THRESHOLD = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic             ex_ready_i,
    input  logic [2:0]       err_a_i,
    input  logic [2:0]       err_b_i,
    input  logic [2:0]       err_c_i,
    input  logic             clear_i,
    output logic [1:0]       spare_sel_o,
    output logic [1:0]       state_o,
    output logic             alarm_o,
    output logic             fault_evt_o,
    output logic [CNT_W-1:0] cnt_a_o,
    output logic [CNT_W-1:0] cnt_b_o,
    output logic [CNT_W-1:0] cnt_c_o
);

    typedef enum logic [1:0] {
        ST_HEALTHY  = 2'd0,
        ST_DEGRADED = 2'd1,
        ST_FAILED   = 2'd2,
        ST_ILLEGAL  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] TH = CNT_W'(THRESHOLD);

    state_e                       r_state;
    logic [1:0]                   r_spare;
    logic                         r_alarm;
    logic                         r_evt;
    logic [2:0][CNT_W-1:0]        r_cnt;

    logic [2:0][2:0]              w_err;
    logic [2:0]                   w_hit;
    logic [2:0]                   w_at_th;
    logic [2:0][CNT_W-1:0]        w_cnt_inc;
    logic                         w_any_th;
    logic                         w_multi_th;
    logic [1:0]                   w_th_idx;

    assign w_err = {err_c_i, err_b_i, err_a_i};

    // Saturating per-replica counters; a stalled EX stage never counts.
    for (genvar g = 0; g < 3; g++) begin : g_rep
        assign w_hit[g]     = enable_i & ex_ready_i & (|w_err[g]);
        assign w_at_th[g]   = (r_cnt[g] == TH);
        assign w_cnt_inc[g] = (w_hit[g] && !w_at_th[g]) ? r_cnt[g] + 1'b1 : r_cnt[g];
    end

    assign w_any_th   = |w_at_th;
    assign w_multi_th = (w_at_th[0] & w_at_th[1]) | (w_at_th[0] & w_at_th[2]) |
                        (w_at_th[1] & w_at_th[2]);

    always_comb begin
        w_th_idx = 2'd0;
        if (w_at_th[0])      w_th_idx = 2'd1;
        else if (w_at_th[1]) w_th_idx = 2'd2;
        else if (w_at_th[2]) w_th_idx = 2'd3;
    end

    // Decisions use the registered counters, so a transition lands one edge after
    // the counter reaches THRESHOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_HEALTHY;
            r_spare <= 2'd0;
            r_alarm <= 1'b0;
            r_evt   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_evt <= 1'b0;
            if (clear_i) begin
                r_state <= ST_HEALTHY;
                r_spare <= 2'd0;
                r_alarm <= 1'b0;
                r_cnt   <= '0;
                r_evt   <= (r_state != ST_HEALTHY);
            end else begin
                case (r_state)
                    ST_HEALTHY: begin
                        if (w_multi_th) begin
                            r_state <= ST_FAILED;
                            r_spare <= 2'd0;
                            r_alarm <= 1'b1;
                            r_evt   <= 1'b1;
                            r_cnt   <= w_cnt_inc;
                        end else if (w_any_th) begin
                            r_state <= ST_DEGRADED;
                            r_spare <= w_th_idx;
                            r_evt   <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt   <= w_cnt_inc;
                        end
                    end
                    ST_DEGRADED: begin
                        r_cnt <= w_cnt_inc;
                        if (w_any_th) begin
                            r_state <= ST_FAILED;
                            r_alarm <= 1'b1;
                            r_evt   <= 1'b1;
                        end
                    end
                    ST_FAILED: begin
                        r_alarm <= 1'b1;
                    end
                    default: begin
                        r_state <= ST_FAILED;
                        r_alarm <= 1'b1;
                        r_evt   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign state_o     = r_state;
    assign spare_sel_o = r_spare;
    assign alarm_o     = r_alarm;
    assign fault_evt_o = r_evt;
    assign cnt_a_o     = r_cnt[0];
    assign cnt_b_o     = r_cnt[1];
    assign cnt_c_o     = r_cnt[2];

endmodule

// File: tb/tb_cv32e40p_alu_fault_manager.sv
// Directed bench for the ALU fault manager: a behavioural model pushes expected
// outputs into a scoreboard queue as each step is driven; they are popped after the edge.
module tb_cv32e40p_alu_fault_manager;

    localparam int TH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable_i, ex_ready_i, clear_i;
    logic [2:0]  err_a_i, err_b_i, err_c_i;
    logic [1:0]  spare_sel_o, state_o;
    logic        alarm_o, fault_evt_o;
    logic [15:0] cnt_a_o, cnt_b_o, cnt_c_o;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [1:0]  st;
        logic [1:0]  sp;
        logic        al;
        logic        ev;
        logic [15:0] ca, cb, cc;
    } exp_t;

    exp_t sb[$];

    logic [1:0]  m_st, m_sp;
    logic        m_al, m_ev;
    logic [15:0] m_cnt [3];

    cv32e40p_alu_fault_manager #(.THRESHOLD(TH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .enable_i(enable_i), .ex_ready_i(ex_ready_i),
        .err_a_i(err_a_i), .err_b_i(err_b_i), .err_c_i(err_c_i), .clear_i(clear_i),
        .spare_sel_o(spare_sel_o), .state_o(state_o), .alarm_o(alarm_o),
        .fault_evt_o(fault_evt_o), .cnt_a_o(cnt_a_o), .cnt_b_o(cnt_b_o), .cnt_c_o(cnt_c_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_st = 2'd0; m_sp = 2'd0; m_al = 1'b0; m_ev = 1'b0;
        for (int i = 0; i < 3; i++) m_cnt[i] = 16'd0;
    endtask

    // Behavioural reference of one clock edge, expressed in spec terms.
    task automatic model_edge(input logic en, input logic rdy, input logic [2:0] ea,
                              input logic [2:0] eb, input logic [2:0] ec, input logic clr);
        logic [2:0] hit;
        logic [15:0] inc [3];
        int n_th;
        int first;
        hit[0] = en & rdy & (|ea);
        hit[1] = en & rdy & (|eb);
        hit[2] = en & rdy & (|ec);
        n_th = 0; first = -1;
        for (int i = 0; i < 3; i++) begin
            inc[i] = (hit[i] && m_cnt[i] < TH) ? m_cnt[i] + 16'd1 : m_cnt[i];
            if (m_cnt[i] == TH) begin
                n_th++;
                if (first < 0) first = i;
            end
        end
        m_ev = 1'b0;
        if (clr) begin
            m_ev = (m_st != 2'd0);
            m_st = 2'd0; m_sp = 2'd0; m_al = 1'b0;
            for (int i = 0; i < 3; i++) m_cnt[i] = 16'd0;
        end else if (m_st == 2'd0) begin
            if (n_th >= 2) begin
                m_st = 2'd2; m_sp = 2'd0; m_al = 1'b1; m_ev = 1'b1;
                for (int i = 0; i < 3; i++) m_cnt[i] = inc[i];
            end else if (n_th == 1) begin
                m_st = 2'd1; m_sp = 2'(first + 1); m_ev = 1'b1;
                for (int i = 0; i < 3; i++) m_cnt[i] = 16'd0;
            end else begin
                for (int i = 0; i < 3; i++) m_cnt[i] = inc[i];
            end
        end else if (m_st == 2'd1) begin
            for (int i = 0; i < 3; i++) m_cnt[i] = inc[i];
            if (n_th >= 1) begin
                m_st = 2'd2; m_al = 1'b1; m_ev = 1'b1;
            end
        end
    endtask

    task automatic step(input logic en, input logic rdy, input logic [2:0] ea,
                        input logic [2:0] eb, input logic [2:0] ec, input logic clr);
        exp_t e;
        @(negedge clk);
        enable_i = en; ex_ready_i = rdy; err_a_i = ea; err_b_i = eb; err_c_i = ec; clear_i = clr;
        model_edge(en, rdy, ea, eb, ec, clr);
        e.st = m_st; e.sp = m_sp; e.al = m_al; e.ev = m_ev;
        e.ca = m_cnt[0]; e.cb = m_cnt[1]; e.cc = m_cnt[2];
        sb.push_back(e);
        @(posedge clk);
        #1;
        vectors++;
        assert (sb.size() != 0) else begin
            miscompares++;
            $error("FAIL sb_empty observed=%0d expected=1", sb.size());
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("state", {14'd0, state_o}, {14'd0, e.st});
            check("spare", {14'd0, spare_sel_o}, {14'd0, e.sp});
            check("alarm", {15'd0, alarm_o}, {15'd0, e.al});
            check("evt", {15'd0, fault_evt_o}, {15'd0, e.ev});
            check("cnt_a", cnt_a_o, e.ca);
            check("cnt_b", cnt_b_o, e.cb);
            check("cnt_c", cnt_c_o, e.cc);
        end
        enable_i = 1'b0; ex_ready_i = 1'b0; clear_i = 1'b0;
        err_a_i = 3'd0; err_b_i = 3'd0; err_c_i = 3'd0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, {14'd0, state_o}, 16'd0);
        check({tag, "_spare"}, {14'd0, spare_sel_o}, 16'd0);
        check({tag, "_alarm"}, {15'd0, alarm_o}, 16'd0);
        check({tag, "_evt"}, {15'd0, fault_evt_o}, 16'd0);
        check({tag, "_cnt_a"}, cnt_a_o, 16'd0);
        check({tag, "_cnt_b"}, cnt_b_o, 16'd0);
        check({tag, "_cnt_c"}, cnt_c_o, 16'd0);
    endtask

    initial begin
        rst = 1'b1; enable_i = 1'b0; ex_ready_i = 1'b0; clear_i = 1'b0;
        err_a_i = 3'd0; err_b_i = 3'd0; err_c_i = 3'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk) rst = 1'b0;

        // Four hits on B walk its counter to THRESHOLD, then DEGRADED with spare on B.
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b1, 3'd0, 3'b001, 3'd0, 1'b0);
            check("b_walk", cnt_b_o, 16'(i));
        end
        idle();
        check("deg_state", {14'd0, state_o}, 16'd1);
        check("deg_spare", {14'd0, spare_sel_o}, 16'd2);
        check("deg_evt", {15'd0, fault_evt_o}, 16'd1);
        check("deg_cnt_b", cnt_b_o, 16'd0);
        idle();
        check("deg_evt_drop", {15'd0, fault_evt_o}, 16'd0);

        // DEGRADED: four hits on C escalate to FAILED with spare held.
        repeat (4) step(1'b1, 1'b1, 3'd0, 3'd0, 3'b010, 1'b0);
        check("c_at_th", cnt_c_o, 16'd4);
        idle();
        check("fail_state", {14'd0, state_o}, 16'd2);
        check("fail_alarm", {15'd0, alarm_o}, 16'd1);
        check("fail_spare", {14'd0, spare_sel_o}, 16'd2);
        repeat (20) step(1'b1, 1'b1, 3'b111, 3'b010, 3'b100, 1'b0);
        check("frozen_c", cnt_c_o, 16'd4);
        check("frozen_a", cnt_a_o, 16'd0);

        // Clear wins over a same-cycle hit on A.
        step(1'b1, 1'b1, 3'b001, 3'd0, 3'd0, 1'b1);
        check("clr_state", {14'd0, state_o}, 16'd0);
        check("clr_alarm", {15'd0, alarm_o}, 16'd0);
        check("clr_cnt_a", cnt_a_o, 16'd0);
        check("clr_evt", {15'd0, fault_evt_o}, 16'd1);

        // Stalled or disabled cycles never count.
        repeat (10) step(1'b1, 1'b0, 3'b100, 3'd0, 3'd0, 1'b0);
        check("stall_cnt_a", cnt_a_o, 16'd0);
        repeat (2) step(1'b0, 1'b1, 3'b100, 3'b001, 3'd0, 1'b0);

        // Simultaneous A and C reach THRESHOLD -> FAILED, no spare.
        repeat (3) step(1'b1, 1'b1, 3'b010, 3'd0, 3'b001, 1'b0);
        check("ac3_a", cnt_a_o, 16'd3);
        step(1'b1, 1'b1, 3'b100, 3'd0, 3'b100, 1'b0);
        idle();
        check("dual_state", {14'd0, state_o}, 16'd2);
        check("dual_alarm", {15'd0, alarm_o}, 16'd1);
        check("dual_spare", {14'd0, spare_sel_o}, 16'd0);

        // Clear in HEALTHY leaves no event; clear discards hits.
        step(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1);
        step(1'b1, 1'b1, 3'b001, 3'b001, 3'b001, 1'b1);
        check("clr_h_evt", {15'd0, fault_evt_o}, 16'd0);
        check("clr_h_cnt_b", cnt_b_o, 16'd0);

        // Multi-replica increments in one cycle.
        step(1'b1, 1'b1, 3'b010, 3'b100, 3'b000, 1'b0);
        step(1'b1, 1'b1, 3'b001, 3'b011, 3'b111, 1'b0);
        check("multi_a", cnt_a_o, 16'd2);
        check("multi_c", cnt_c_o, 16'd1);
        step(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1);

        // Mid-stream reset with B at 3: async zeroing, then full recount.
        repeat (3) step(1'b1, 1'b1, 3'd0, 3'b001, 3'd0, 1'b0);
        check("pre_rst_b", cnt_b_o, 16'd3);
        @(negedge clk);
        rst = 1'b1;
        #1 check_all_zero("async_rst");
        model_reset();
        @(negedge clk) rst = 1'b0;
        repeat (3) step(1'b1, 1'b1, 3'd0, 3'b001, 3'd0, 1'b0);
        idle();
        check("post_rst_state", {14'd0, state_o}, 16'd0);
        step(1'b1, 1'b1, 3'd0, 3'b001, 3'd0, 1'b0);
        idle();
        check("post_rst_deg", {14'd0, state_o}, 16'd1);
        check("post_rst_spare", {14'd0, spare_sel_o}, 16'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
